// File: rtl/switch_debounce_toggle_if.sv
// Bundle of the four switch channels: raw pins in, conditioned level/pulse/toggle out.
// The master drives the raw pins; the slave is the conditioning block.
interface switch_debounce_toggle_if;
  logic [3:0] i_Switch;
  logic [3:0] o_Sw_Level;
  logic [3:0] o_Press;
  logic [3:0] o_Release;
  logic [3:0] o_Toggle;

  modport master (
    output i_Switch,
    input  o_Sw_Level,
    input  o_Press,
    input  o_Release,
    input  o_Toggle
  );

  modport slave (
    input  i_Switch,
    output o_Sw_Level,
    output o_Press,
    output o_Release,
    output o_Toggle
  );
endinterface

// File: rtl/switch_debounce_toggle.sv
// Four-channel push-button conditioner: 2-flop synchroniser, stability-counter debounce,
// registered press/release pulses and a press-toggled latch per channel.
module switch_debounce_toggle #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_WIDTH       = 18
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_n,
  switch_debounce_toggle_if.slave sw
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [3:0]                sync_p0;
  logic [3:0]                sync_p1;
  logic [3:0][CNT_WIDTH-1:0] cnt_p2;
  logic [3:0]                level_p2;
  logic [3:0]                press_p2;
  logic [3:0]                release_p2;
  logic [3:0]                toggle_p3;
  logic [3:0]                accept;

  // Stage p0/p1: two-flop synchroniser, nothing between the flops
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= sw.i_Switch;
      sync_p1 <= sync_p0;
    end
  end

  always_comb begin
    accept = '0;
    for (int k = 0; k < 4; k++) begin
      accept[k] = (sync_p1[k] != level_p2[k]) && (cnt_p2[k] == CNT_LAST);
    end
  end

  // Stage p2: debounce; any agreeing sample discards the count, acceptance clears it
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      cnt_p2     <= '0;
      level_p2   <= '0;
      press_p2   <= '0;
      release_p2 <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (sync_p1[k] == level_p2[k]) begin
          cnt_p2[k] <= '0;
        end else if (accept[k]) begin
          cnt_p2[k]   <= '0;
          level_p2[k] <= sync_p1[k];
        end else begin
          cnt_p2[k] <= cnt_p2[k] + CNT_WIDTH'(1);
        end
      end
      press_p2   <= accept & sync_p1;
      release_p2 <= accept & ~sync_p1;
    end
  end

  // Stage p3: toggle latch flips on the press pulse, visible the following cycle
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      toggle_p3 <= '0;
    end else begin
      toggle_p3 <= toggle_p3 ^ press_p2;
    end
  end

  assign sw.o_Sw_Level = level_p2;
  assign sw.o_Press    = press_p2;
  assign sw.o_Release  = release_p2;
  assign sw.o_Toggle   = toggle_p3;

endmodule

// File: tb/tb_switch_debounce_toggle.sv
// Bench for switch_debounce_toggle: directed scenarios plus random bouncing pins,
// checked against a sample-window reference model.
module tb_switch_debounce_toggle;

  localparam int D = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  switch_debounce_toggle_if sw ();

  switch_debounce_toggle #(
    .DEBOUNCE_CYCLES(D),
    .CNT_WIDTH      (3)
  ) dut (
    .i_Clk  (clk),
    .i_Rst_n(rst_n),
    .sw     (sw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a level is accepted once the last D synchronised samples
  // (pin value from two edges earlier) all disagree with the current level.
  logic [3:0] pin_log[$];
  logic [3:0] m_level   = '0;
  logic [3:0] m_press   = '0;
  logic [3:0] m_release = '0;
  logic [3:0] m_toggle  = '0;
  logic [3:0] np, nr;
  logic       all_diff, s;
  int         sz, idx;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pin_log.delete();
      m_level = '0; m_press = '0; m_release = '0; m_toggle = '0;
    end else begin
      pin_log.push_back(sw.i_Switch);
      m_toggle = m_toggle ^ m_press;
      np = '0; nr = '0;
      sz = pin_log.size();
      for (int k = 0; k < 4; k++) begin
        all_diff = 1'b1;
        for (int j = 0; j < D; j++) begin
          idx = sz - 3 - j;
          s = (idx >= 0) ? pin_log[idx][k] : 1'b0;
          if (s == m_level[k]) all_diff = 1'b0;
        end
        if (all_diff) begin
          m_level[k] = ~m_level[k];
          if (m_level[k]) np[k] = 1'b1;
          else            nr[k] = 1'b1;
        end
      end
      m_press = np;
      m_release = nr;
    end
  end

  task automatic test_reset();
    sw.i_Switch = 4'hF;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      checks++;
      if ({sw.o_Sw_Level, sw.o_Press, sw.o_Release, sw.o_Toggle} !== {m_level, m_press, m_release, m_toggle}) begin
        errors++;
        $display("FAIL reset_pre_model e=%0d: got %h expected %h", e,
                 {sw.o_Sw_Level, sw.o_Press, sw.o_Release, sw.o_Toggle}, {m_level, m_press, m_release, m_toggle});
      end
    end
    checks++;
    if (sw.o_Sw_Level !== 4'hF) begin
      errors++;
      $display("FAIL reset_pre_level: got %h expected f", sw.o_Sw_Level);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({sw.o_Sw_Level, sw.o_Press, sw.o_Release, sw.o_Toggle} !== 16'h0) begin
      errors++;
      $display("FAIL reset_async: got %h expected 0000", {sw.o_Sw_Level, sw.o_Press, sw.o_Release, sw.o_Toggle});
    end
    for (int e = 1; e <= 3; e++) begin
      @(negedge clk);
      checks++;
      if ({sw.o_Sw_Level, sw.o_Press, sw.o_Release, sw.o_Toggle} !== 16'h0) begin
        errors++;
        $display("FAIL reset_hold e=%0d: got %h expected 0000", e, {sw.o_Sw_Level, sw.o_Press, sw.o_Release, sw.o_Toggle});
      end
    end
    sw.i_Switch = 4'h0;
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      checks++;
      if ({sw.o_Sw_Level, sw.o_Press, sw.o_Release, sw.o_Toggle} !== 16'h0) begin
        errors++;
        $display("FAIL reset_after e=%0d: got %h expected 0000", e, {sw.o_Sw_Level, sw.o_Press, sw.o_Release, sw.o_Toggle});
      end
    end
  endtask

  task automatic test_clean_press();
    sw.i_Switch = 4'b0001;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      checks++;
      if (sw.o_Sw_Level !== ((e >= 6) ? 4'b0001 : 4'b0000)) begin
        errors++;
        $display("FAIL press_level e=%0d: got %b expected %b", e, sw.o_Sw_Level, (e >= 6) ? 4'b0001 : 4'b0000);
      end
      checks++;
      if (sw.o_Press !== ((e == 6) ? 4'b0001 : 4'b0000)) begin
        errors++;
        $display("FAIL press_pulse e=%0d: got %b expected %b", e, sw.o_Press, (e == 6) ? 4'b0001 : 4'b0000);
      end
      checks++;
      if (sw.o_Toggle !== ((e >= 7) ? 4'b0001 : 4'b0000)) begin
        errors++;
        $display("FAIL press_toggle e=%0d: got %b expected %b", e, sw.o_Toggle, (e >= 7) ? 4'b0001 : 4'b0000);
      end
    end
  endtask

  task automatic test_bounce_reject();
    logic [14:0] pat;
    pat = 15'b000000001110111;
    for (int i = 0; i < 15; i++) begin
      sw.i_Switch = {2'b00, pat[i], 1'b1};
      @(negedge clk);
      checks++;
      if ({sw.o_Sw_Level[1], sw.o_Press[1], sw.o_Toggle[1]} !== 3'b000) begin
        errors++;
        $display("FAIL bounce_ch1 i=%0d: got %b expected 000", i, {sw.o_Sw_Level[1], sw.o_Press[1], sw.o_Toggle[1]});
      end
      checks++;
      if ({sw.o_Sw_Level, sw.o_Press, sw.o_Release, sw.o_Toggle} !== {m_level, m_press, m_release, m_toggle}) begin
        errors++;
        $display("FAIL bounce_model i=%0d: got %h expected %h", i,
                 {sw.o_Sw_Level, sw.o_Press, sw.o_Release, sw.o_Toggle}, {m_level, m_press, m_release, m_toggle});
      end
    end
  endtask

  task automatic test_release_repress();
    int n_rel, n_press;
    n_rel = 0;
    sw.i_Switch = 4'b0000;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      if (sw.o_Release[0] === 1'b1) n_rel++;
      checks++;
      if (sw.o_Toggle[0] !== 1'b1) begin
        errors++;
        $display("FAIL release_toggle_kept e=%0d: got %b expected 1", e, sw.o_Toggle[0]);
      end
    end
    checks++;
    if (n_rel != 1 || sw.o_Sw_Level[0] !== 1'b0) begin
      errors++;
      $display("FAIL release_pulse: got %0d pulses level %b expected 1 pulses level 0", n_rel, sw.o_Sw_Level[0]);
    end
    n_press = 0;
    sw.i_Switch = 4'b0001;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      if (sw.o_Press[0] === 1'b1) n_press++;
    end
    checks++;
    if (n_press != 1 || sw.o_Toggle[0] !== 1'b0) begin
      errors++;
      $display("FAIL repress: got %0d pulses toggle %b expected 1 pulses toggle 0", n_press, sw.o_Toggle[0]);
    end
  endtask

  task automatic test_simultaneous();
    sw.i_Switch = 4'h0;
    repeat (8) @(negedge clk);
    sw.i_Switch = 4'hF;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      checks++;
      if (sw.o_Press !== ((e == 6) ? 4'hF : 4'h0)) begin
        errors++;
        $display("FAIL simul_press e=%0d: got %h expected %h", e, sw.o_Press, (e == 6) ? 4'hF : 4'h0);
      end
      if (e == 7) begin
        checks++;
        if (sw.o_Toggle !== 4'hF) begin
          errors++;
          $display("FAIL simul_toggle: got %h expected f", sw.o_Toggle);
        end
      end
    end
  endtask

  task automatic test_reset_mid_count();
    sw.i_Switch = 4'h0;
    repeat (8) @(negedge clk);
    sw.i_Switch = 4'b0100;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk);
      #1;
      checks++;
      if (sw.o_Press !== 4'h0) begin
        errors++;
        $display("FAIL midcnt_no_early e=%0d: got %h expected 0", e, sw.o_Press);
      end
    end
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({sw.o_Sw_Level, sw.o_Press, sw.o_Toggle} !== 12'h0) begin
      errors++;
      $display("FAIL midcnt_in_reset: got %h expected 000", {sw.o_Sw_Level, sw.o_Press, sw.o_Toggle});
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      checks++;
      if (sw.o_Press !== ((e == 6) ? 4'b0100 : 4'b0000)) begin
        errors++;
        $display("FAIL midcnt_press e=%0d: got %b expected %b", e, sw.o_Press, (e == 6) ? 4'b0100 : 4'b0000);
      end
    end
  endtask

  task automatic test_random();
    int hold[4];
    logic [3:0] pins;
    pins = sw.i_Switch;
    for (int k = 0; k < 4; k++) hold[k] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 4; k++) begin
        if (hold[k] == 0) begin
          pins[k] = 1'($urandom_range(0, 1));
          hold[k] = $urandom_range(1, 7);
        end
        hold[k]--;
      end
      sw.i_Switch = pins;
      @(negedge clk);
      checks++;
      if ({sw.o_Sw_Level, sw.o_Press, sw.o_Release, sw.o_Toggle} !== {m_level, m_press, m_release, m_toggle}) begin
        errors++;
        $display("FAIL random_model c=%0d: got %h expected %h", c,
                 {sw.o_Sw_Level, sw.o_Press, sw.o_Release, sw.o_Toggle}, {m_level, m_press, m_release, m_toggle});
      end
      checks++;
      if ((sw.o_Press & sw.o_Release) !== 4'h0) begin
        errors++;
        $display("FAIL random_excl c=%0d: got %h expected 0", c, sw.o_Press & sw.o_Release);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    sw.i_Switch = 4'h0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_clean_press();
    test_bounce_reject();
    test_release_repress();
    test_simultaneous();
    test_reset_mid_count();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
